// File: rtl/write_controller.sv
// Write-path arbitration core for a 2-master x 4-slave AXI interconnect.
// It grants one AW request round-robin, decodes the target slave and sequences AW, W and B for that single transaction.
module write_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter bit RR_INIT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] slave0_addr1,
    input  logic [ADDR_WIDTH-1:0] slave0_addr2,
    input  logic [ADDR_WIDTH-1:0] slave1_addr1,
    input  logic [ADDR_WIDTH-1:0] slave1_addr2,
    input  logic [ADDR_WIDTH-1:0] slave2_addr1,
    input  logic [ADDR_WIDTH-1:0] slave2_addr2,
    input  logic [ADDR_WIDTH-1:0] slave3_addr1,
    input  logic [ADDR_WIDTH-1:0] slave3_addr2,
    input  logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic                  M0_AWVALID,
    input  logic                  M1_AWVALID,
    input  logic                  M0_WVALID,
    input  logic                  M1_WVALID,
    input  logic                  M0_WLAST,
    input  logic                  M1_WLAST,
    input  logic                  M0_BREADY,
    input  logic                  M1_BREADY,
    input  logic                  S0_AWREADY,
    input  logic                  S1_AWREADY,
    input  logic                  S2_AWREADY,
    input  logic                  S3_AWREADY,
    input  logic                  S0_WREADY,
    input  logic                  S1_WREADY,
    input  logic                  S2_WREADY,
    input  logic                  S3_WREADY,
    input  logic                  S0_BVALID,
    input  logic                  S1_BVALID,
    input  logic                  S2_BVALID,
    input  logic                  S3_BVALID,
    output logic                  select_master_address,
    output logic [1:0]            select_slave_address,
    output logic [1:0]            select_resp_M0,
    output logic [1:0]            select_resp_M1,
    output logic                  resp_en_M0,
    output logic                  resp_en_M1,
    output logic [1:0]            en_S0,
    output logic [1:0]            en_S1,
    output logic [1:0]            en_S2,
    output logic [1:0]            en_S3,
    output logic                  err_awready,
    output logic                  err_wready,
    output logic                  err_bvalid
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_ADDR, ST_DATA, ST_RESP, ST_ERR_ADDR, ST_ERR_DATA, ST_ERR_RESP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_grant;
    logic       r_rr;
    logic [1:0] r_slave;
    logic [1:0] r_resp_m0;
    logic [1:0] r_resp_m1;

    logic       w_awvalid_g, w_wvalid_g, w_wlast_g, w_bready_g;
    logic       w_any_req, w_req_grant, w_txn_done;
    logic [3:0] w_s_awready, w_s_wready, w_s_bvalid, w_hit;
    logic [1:0] w_match_idx;
    logic [3:0] w_en_aw, w_en_w;
    logic       w_err_aw, w_err_w, w_err_b, w_resp_en;

    // Master-side signals are taken from whichever master holds the grant.
    assign w_awvalid_g = r_grant ? M1_AWVALID : M0_AWVALID;
    assign w_wvalid_g  = r_grant ? M1_WVALID  : M0_WVALID;
    assign w_wlast_g   = r_grant ? M1_WLAST   : M0_WLAST;
    assign w_bready_g  = r_grant ? M1_BREADY  : M0_BREADY;

    assign w_s_awready = {S3_AWREADY, S2_AWREADY, S1_AWREADY, S0_AWREADY};
    assign w_s_wready  = {S3_WREADY, S2_WREADY, S1_WREADY, S0_WREADY};
    assign w_s_bvalid  = {S3_BVALID, S2_BVALID, S1_BVALID, S0_BVALID};

    assign w_hit[0] = (M_ADDR >= slave0_addr1) && (M_ADDR <= slave0_addr2);
    assign w_hit[1] = (M_ADDR >= slave1_addr1) && (M_ADDR <= slave1_addr2);
    assign w_hit[2] = (M_ADDR >= slave2_addr1) && (M_ADDR <= slave2_addr2);
    assign w_hit[3] = (M_ADDR >= slave3_addr1) && (M_ADDR <= slave3_addr2);

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        w_match_idx = 2'd3;
        if (w_hit[0])      w_match_idx = 2'd0;
        else if (w_hit[1]) w_match_idx = 2'd1;
        else if (w_hit[2]) w_match_idx = 2'd2;
    end

    assign w_any_req   = M0_AWVALID || M1_AWVALID;
    assign w_req_grant = (M0_AWVALID && M1_AWVALID) ? r_rr : M1_AWVALID;

    always_comb begin
        w_next     = r_state;
        w_txn_done = 1'b0;
        w_en_aw    = 4'b0000;
        w_en_w     = 4'b0000;
        w_err_aw   = 1'b0;
        w_err_w    = 1'b0;
        w_err_b    = 1'b0;
        w_resp_en  = 1'b0;
        case (r_state)
            ST_IDLE:     if (w_any_req) w_next = ST_DECODE;
            ST_DECODE:   w_next = (|w_hit) ? ST_ADDR : ST_ERR_ADDR;
            ST_ADDR: begin
                w_en_aw[r_slave] = 1'b1;
                if (w_awvalid_g && w_s_awready[r_slave]) w_next = ST_DATA;
            end
            ST_DATA: begin
                w_en_w[r_slave] = 1'b1;
                if (w_wvalid_g && w_s_wready[r_slave] && w_wlast_g) w_next = ST_RESP;
            end
            ST_RESP: begin
                w_resp_en = 1'b1;
                if (w_s_bvalid[r_slave] && w_bready_g) begin
                    w_next     = ST_IDLE;
                    w_txn_done = 1'b1;
                end
            end
            ST_ERR_ADDR: begin
                w_err_aw = 1'b1;
                w_next   = ST_ERR_DATA;
            end
            ST_ERR_DATA: begin
                w_err_w = 1'b1;
                if (w_wvalid_g && w_wlast_g) w_next = ST_ERR_RESP;
            end
            ST_ERR_RESP: begin
                w_err_b = 1'b1;
                if (w_bready_g) begin
                    w_next     = ST_IDLE;
                    w_txn_done = 1'b1;
                end
            end
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= 1'b0;
            r_rr      <= RR_INIT;
            r_slave   <= 2'd0;
            r_resp_m0 <= 2'd0;
            r_resp_m1 <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any_req) r_grant <= w_req_grant;
            if (r_state == ST_DECODE && (|w_hit)) r_slave <= w_match_idx;
            // The B route is latched on entry to RESP so it persists after the handshake.
            if (r_state == ST_DATA && w_next == ST_RESP) begin
                if (r_grant) r_resp_m1 <= r_slave;
                else         r_resp_m0 <= r_slave;
            end
            if (w_txn_done) r_rr <= ~r_grant;
        end
    end

    assign select_master_address = r_grant;
    assign select_slave_address  = r_slave;
    assign select_resp_M0        = r_resp_m0;
    assign select_resp_M1        = r_resp_m1;
    assign resp_en_M0            = w_resp_en && !r_grant;
    assign resp_en_M1            = w_resp_en && r_grant;
    assign en_S0                 = {w_en_w[0], w_en_aw[0]};
    assign en_S1                 = {w_en_w[1], w_en_aw[1]};
    assign en_S2                 = {w_en_w[2], w_en_aw[2]};
    assign en_S3                 = {w_en_w[3], w_en_aw[3]};
    assign err_awready           = w_err_aw;
    assign err_wready            = w_err_w;
    assign err_bvalid            = w_err_b;

endmodule
